// File: rtl/rf80386_bus_arbiter.sv
// Two-port bus arbiter: a data port and an instruction-fetch port share one
// split-response bus. One transaction is outstanding at a time; responses are
// matched by transaction id, retries back off and reissue, and silence times out.
module rf80386_bus_arbiter #(
  parameter int unsigned RTY_WAIT = 8,
  parameter int unsigned TIMEOUT  = 31,
  parameter int unsigned STARVE   = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         if_req_i,
  input  logic [31:0]  if_adr_i,
  output logic         if_done_o,
  output logic         if_err_o,
  input  logic         d_req_i,
  input  logic         d_we_i,
  input  logic [31:0]  d_adr_i,
  input  logic [15:0]  d_sel_i,
  input  logic [127:0] d_dat_i,
  output logic         d_done_o,
  output logic         d_err_o,
  output logic [127:0] rdat_o,
  output logic         bus_cyc_o,
  output logic         bus_stb_o,
  output logic         bus_we_o,
  output logic [31:0]  bus_adr_o,
  output logic [15:0]  bus_sel_o,
  output logic [127:0] bus_dat_o,
  output logic [3:0]   bus_tid_o,
  input  logic         bus_ack_i,
  input  logic         bus_rty_i,
  input  logic [3:0]   bus_tid_i,
  input  logic [127:0] bus_dat_i
);

  localparam int unsigned StarveW = (STARVE > 0) ? $clog2(STARVE + 1) : 1;
  localparam int unsigned WaitW   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int unsigned BoffW   = (RTY_WAIT > 0) ? $clog2(RTY_WAIT + 1) : 1;

  localparam logic [StarveW-1:0] StarveMax = StarveW'(STARVE);
  localparam logic [WaitW-1:0]   WaitLast  = WaitW'(TIMEOUT - 1);
  localparam logic [BoffW-1:0]   BoffLast  = BoffW'(RTY_WAIT - 1);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StBackoff} state_e;

  state_e               state_q, state_d;
  logic                 own_if_q, own_if_d;
  logic                 we_q, we_d;
  logic [31:0]          adr_q, adr_d;
  logic [15:0]          sel_q, sel_d;
  logic [127:0]         dat_q, dat_d;
  logic [3:0]           tid_q, tid_d;          // next tid to issue
  logic [3:0]           out_tid_q, out_tid_d;  // tid of the outstanding transaction
  logic [WaitW-1:0]     wait_cnt_q, wait_cnt_d;
  logic [BoffW-1:0]     boff_cnt_q, boff_cnt_d;
  logic [StarveW-1:0]   starve_q, starve_d;
  logic                 if_done_q, if_done_d;
  logic                 d_done_q, d_done_d;
  logic                 if_err_q, if_err_d;
  logic                 d_err_q, d_err_d;
  logic [127:0]         rdat_q, rdat_d;
  logic                 tid_match;

  assign tid_match = (bus_tid_i == out_tid_q);

  // Next-state: arbitration, issue, response matching, backoff and timeout.
  always_comb begin
    state_d    = state_q;
    own_if_d   = own_if_q;
    we_d       = we_q;
    adr_d      = adr_q;
    sel_d      = sel_q;
    dat_d      = dat_q;
    tid_d      = tid_q;
    out_tid_d  = out_tid_q;
    wait_cnt_d = wait_cnt_q;
    boff_cnt_d = boff_cnt_q;
    starve_d   = starve_q;
    rdat_d     = rdat_q;
    if_done_d  = 1'b0;
    d_done_d   = 1'b0;
    if_err_d   = 1'b0;
    d_err_d    = 1'b0;

    unique case (state_q)
      StIdle: begin
        // No grant while a done is pulsing, so requesters see done first.
        if (!if_done_q && !d_done_q) begin
          if (if_req_i && (!d_req_i || starve_q == StarveMax)) begin
            own_if_d = 1'b1;
            we_d     = 1'b0;
            adr_d    = if_adr_i;
            sel_d    = 16'hFFFF;
            dat_d    = '0;
            starve_d = '0;
            state_d  = StIssue;
          end else if (d_req_i) begin
            own_if_d = 1'b0;
            we_d     = d_we_i;
            adr_d    = d_adr_i;
            sel_d    = d_sel_i;
            dat_d    = d_dat_i;
            if (if_req_i && starve_q != StarveMax) starve_d = starve_q + 1'b1;
            state_d  = StIssue;
          end
        end
      end
      StIssue: begin
        out_tid_d  = tid_q;
        tid_d      = (tid_q == 4'd15) ? 4'd1 : tid_q + 4'd1;
        wait_cnt_d = '0;
        state_d    = StWait;
      end
      StWait: begin
        if (tid_match && bus_ack_i) begin
          if_done_d = own_if_q;
          d_done_d  = !own_if_q;
          rdat_d    = bus_dat_i;
          state_d   = StIdle;
        end else if (tid_match && bus_rty_i) begin
          boff_cnt_d = '0;
          state_d    = StBackoff;
        end else if (wait_cnt_q == WaitLast) begin
          if_done_d = own_if_q;
          d_done_d  = !own_if_q;
          if_err_d  = own_if_q;
          d_err_d   = !own_if_q;
          rdat_d    = '0;
          state_d   = StIdle;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      StBackoff: begin
        if (boff_cnt_q == BoffLast) begin
          state_d = StIssue;
        end else begin
          boff_cnt_d = boff_cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q    <= StIdle;
      own_if_q   <= 1'b0;
      we_q       <= 1'b0;
      adr_q      <= '0;
      sel_q      <= '0;
      dat_q      <= '0;
      tid_q      <= 4'd1;
      out_tid_q  <= 4'd1;
      wait_cnt_q <= '0;
      boff_cnt_q <= '0;
      starve_q   <= '0;
      rdat_q     <= '0;
      if_done_q  <= 1'b0;
      d_done_q   <= 1'b0;
      if_err_q   <= 1'b0;
      d_err_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      own_if_q   <= own_if_d;
      we_q       <= we_d;
      adr_q      <= adr_d;
      sel_q      <= sel_d;
      dat_q      <= dat_d;
      tid_q      <= tid_d;
      out_tid_q  <= out_tid_d;
      wait_cnt_q <= wait_cnt_d;
      boff_cnt_q <= boff_cnt_d;
      starve_q   <= starve_d;
      rdat_q     <= rdat_d;
      if_done_q  <= if_done_d;
      d_done_q   <= d_done_d;
      if_err_q   <= if_err_d;
      d_err_q    <= d_err_d;
    end
  end

  // Bus outputs decoded from state; the tid shown during issue is the fresh one.
  always_comb begin
    bus_cyc_o = (state_q == StIssue) || (state_q == StWait);
    bus_stb_o = (state_q == StIssue);
    bus_tid_o = (state_q == StIssue) ? tid_q : out_tid_q;
  end

  assign bus_we_o  = we_q;
  assign bus_adr_o = adr_q;
  assign bus_sel_o = sel_q;
  assign bus_dat_o = dat_q;
  assign if_done_o = if_done_q;
  assign d_done_o  = d_done_q;
  assign if_err_o  = if_err_q;
  assign d_err_o   = d_err_q;
  assign rdat_o    = rdat_q;

endmodule

// File: tb/tb_rf80386_bus_arbiter.sv
// Self-checking bench for rf80386_bus_arbiter: a vector table of single
// transactions plus sequences for contention, tid wrap and mid-transaction reset.
module tb_rf80386_bus_arbiter;

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b0;
  logic         if_req_i = 1'b0;
  logic [31:0]  if_adr_i = '0;
  logic         if_done_o, if_err_o;
  logic         d_req_i = 1'b0;
  logic         d_we_i = 1'b0;
  logic [31:0]  d_adr_i = '0;
  logic [15:0]  d_sel_i = '0;
  logic [127:0] d_dat_i = '0;
  logic         d_done_o, d_err_o;
  logic [127:0] rdat_o;
  logic         bus_cyc_o, bus_stb_o, bus_we_o;
  logic [31:0]  bus_adr_o;
  logic [15:0]  bus_sel_o;
  logic [127:0] bus_dat_o;
  logic [3:0]   bus_tid_o;
  logic         bus_ack_i = 1'b0;
  logic         bus_rty_i = 1'b0;
  logic [3:0]   bus_tid_i = '0;
  logic [127:0] bus_dat_i = '0;

  rf80386_bus_arbiter dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .if_req_i(if_req_i), .if_adr_i(if_adr_i), .if_done_o(if_done_o), .if_err_o(if_err_o),
    .d_req_i(d_req_i), .d_we_i(d_we_i), .d_adr_i(d_adr_i), .d_sel_i(d_sel_i),
    .d_dat_i(d_dat_i), .d_done_o(d_done_o), .d_err_o(d_err_o), .rdat_o(rdat_o),
    .bus_cyc_o(bus_cyc_o), .bus_stb_o(bus_stb_o), .bus_we_o(bus_we_o),
    .bus_adr_o(bus_adr_o), .bus_sel_o(bus_sel_o), .bus_dat_o(bus_dat_o),
    .bus_tid_o(bus_tid_o), .bus_ack_i(bus_ack_i), .bus_rty_i(bus_rty_i),
    .bus_tid_i(bus_tid_i), .bus_dat_i(bus_dat_i)
  );

  always #5 clk_i = ~clk_i;

  localparam int KAck = 0, KStale = 1, KRetry = 2, KTimeout = 3;

  typedef struct {
    logic         is_if;
    logic         we;
    logic [31:0]  adr;
    logic [15:0]  sel;
    logic [127:0] dat;
    int           kind;
    int           dly;
    logic [127:0] rsp;
    logic         exp_we;
    logic [15:0]  exp_sel;
    logic         exp_err;
    logic [127:0] exp_rdat;
  } vec_t;

  typedef struct {
    logic         is_if;
    logic         err;
    logic [127:0] rdat;
  } sb_t;

  sb_t  sb_q[$];
  int   n_checks = 0;
  int   n_pass = 0;
  logic [3:0] exp_tid = 4'd1;

  function automatic logic [3:0] nxt(input logic [3:0] t);
    return (t == 4'd15) ? 4'd1 : t + 4'd1;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic wait_stb(output bit ok);
    int n = 0;
    ok = 1'b0;
    while (n < 64 && !ok) begin
      @(negedge clk_i);
      if (bus_stb_o) ok = 1'b1;
      n++;
    end
    if (!ok) chk("stb_seen", 0, 1);
  endtask

  task automatic ack_pulse(input logic [3:0] tid, input logic [127:0] d);
    @(negedge clk_i);
    bus_ack_i = 1'b1; bus_tid_i = tid; bus_dat_i = d;
    @(negedge clk_i);
    bus_ack_i = 1'b0; bus_dat_i = '0;
  endtask

  // Waits (bounded) for a done, then compares it against the scoreboard head.
  task automatic wait_check_done(input string tag, output int n);
    sb_t e;
    n = 0;
    while (!(if_done_o || d_done_o) && n < 64) begin
      @(negedge clk_i);
      n++;
    end
    if (!(if_done_o || d_done_o)) begin
      chk({tag, "_done_seen"}, 0, 1);
      return;
    end
    if (sb_q.size() == 0) begin
      chk({tag, "_unexpected_done"}, 1, 0);
      return;
    end
    e = sb_q.pop_front();
    chk({tag, "_if_done"}, if_done_o, e.is_if);
    chk({tag, "_d_done"}, d_done_o, !e.is_if);
    chk({tag, "_err"}, e.is_if ? if_err_o : d_err_o, e.err);
    chk({tag, "_rdat"}, rdat_o, e.rdat);
    @(negedge clk_i);
    chk({tag, "_done_width"}, {if_done_o, d_done_o}, 2'b00);
  endtask

  task automatic check_issue(input string tag, input logic [31:0] adr, input logic [15:0] sel,
                             input logic we);
    chk({tag, "_tid"}, bus_tid_o, exp_tid);
    chk({tag, "_adr"}, bus_adr_o, adr);
    chk({tag, "_sel"}, bus_sel_o, sel);
    chk({tag, "_we"}, bus_we_o, we);
    exp_tid = nxt(exp_tid);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    bit ok;
    int n;
    logic [3:0] cur;
    string tag;
    tag = $sformatf("vec%0d", idx);
    @(negedge clk_i);
    if (v.is_if) begin
      if_req_i = 1'b1; if_adr_i = v.adr;
    end else begin
      d_req_i = 1'b1; d_we_i = v.we; d_adr_i = v.adr; d_sel_i = v.sel; d_dat_i = v.dat;
    end
    wait_stb(ok);
    // Dropping req after grant must not cancel the transaction.
    if_req_i = 1'b0; d_req_i = 1'b0;
    if (!ok) return;
    cur = exp_tid;
    check_issue(tag, v.adr, v.exp_sel, v.exp_we);
    if (v.exp_we) chk({tag, "_wdat"}, bus_dat_o, v.dat);
    sb_q.push_back('{is_if: v.is_if, err: v.exp_err, rdat: v.exp_rdat});
    case (v.kind)
      KStale: begin
        ack_pulse(cur - 4'd1, 128'hDEAD);
        chk({tag, "_stale_ignored"}, {if_done_o, d_done_o, bus_cyc_o}, 3'b001);
      end
      KRetry: begin
        @(negedge clk_i);
        bus_rty_i = 1'b1; bus_tid_i = cur;
        @(negedge clk_i);
        bus_rty_i = 1'b0;
        n = 0;
        while (!bus_stb_o && n < 40) begin
          if (!bus_cyc_o) n++;
          @(negedge clk_i);
        end
        chk({tag, "_backoff_len"}, n, 8);
        chk({tag, "_no_done_on_rty"}, {if_done_o, d_done_o}, 2'b00);
        cur = exp_tid;
        check_issue({tag, "_reissue"}, v.adr, v.exp_sel, v.exp_we);
        chk({tag, "_reissue_dat"}, bus_dat_o, v.dat);
      end
      default: ;
    endcase
    if (v.kind == KTimeout) begin
      wait_check_done(tag, n);
      chk({tag, "_timeout_cycles"}, n, 32);
      chk({tag, "_idle_after"}, bus_cyc_o, 0);
    end else begin
      repeat (v.dly - 1) @(negedge clk_i);
      ack_pulse(cur, v.rsp);
      wait_check_done(tag, n);
    end
  endtask

  vec_t vecs[6];

  initial begin
    bit ok;
    int n;
    int dones;
    logic [3:0] old_tid;

    vecs[0] = '{is_if: 0, we: 0, adr: 32'h1000, sel: 16'h000F, dat: '0, kind: KAck, dly: 3,
                rsp: 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, exp_we: 0,
                exp_sel: 16'h000F, exp_err: 0,
                exp_rdat: 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210};
    vecs[1] = '{is_if: 0, we: 1, adr: 32'h2000, sel: 16'hFFFF, dat: 128'hA5A5_0000_1111_2222,
                kind: KAck, dly: 1, rsp: 128'h77, exp_we: 1, exp_sel: 16'hFFFF, exp_err: 0,
                exp_rdat: 128'h77};
    vecs[2] = '{is_if: 0, we: 0, adr: 32'h2040, sel: 16'h0F00, dat: '0, kind: KStale, dly: 2,
                rsp: 128'hBEEF, exp_we: 0, exp_sel: 16'h0F00, exp_err: 0, exp_rdat: 128'hBEEF};
    vecs[3] = '{is_if: 1, we: 0, adr: 32'h3000, sel: 16'h0000, dat: '0, kind: KAck, dly: 2,
                rsp: 128'hC0DE_C0DE, exp_we: 0, exp_sel: 16'hFFFF, exp_err: 0,
                exp_rdat: 128'hC0DE_C0DE};
    vecs[4] = '{is_if: 0, we: 1, adr: 32'h4444, sel: 16'h00F0, dat: 128'h5555_6666, kind: KRetry,
                dly: 2, rsp: 128'h99, exp_we: 1, exp_sel: 16'h00F0, exp_err: 0, exp_rdat: 128'h99};
    vecs[5] = '{is_if: 1, we: 0, adr: 32'h5000, sel: 16'h0000, dat: '0, kind: KTimeout, dly: 0,
                rsp: '0, exp_we: 0, exp_sel: 16'hFFFF, exp_err: 1, exp_rdat: '0};

    // Reset state.
    repeat (3) @(negedge clk_i);
    chk("reset_cyc", bus_cyc_o, 0);
    chk("reset_stb", bus_stb_o, 0);
    chk("reset_tid", bus_tid_o, 4'd1);
    chk("reset_dones", {if_done_o, d_done_o, if_err_o, d_err_o}, 4'b0000);
    chk("reset_rdat", rdat_o, '0);
    chk("reset_adr", bus_adr_o, '0);
    rst_i = 1'b1;

    for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

    // Contention: four data grants then one ifetch grant, repeating.
    @(negedge clk_i);
    if_req_i = 1'b1; if_adr_i = 32'h6000;
    d_req_i = 1'b1; d_we_i = 1'b0; d_adr_i = 32'h7000; d_sel_i = 16'h00F0; d_dat_i = '0;
    for (int k = 0; k < 10; k++) begin
      logic want_if;
      logic [3:0] t;
      want_if = (k % 5 == 4);
      wait_stb(ok);
      if (!ok) break;
      t = exp_tid;
      check_issue($sformatf("contend%0d", k), want_if ? 32'h6000 : 32'h7000,
                  want_if ? 16'hFFFF : 16'h00F0, 1'b0);
      sb_q.push_back('{is_if: want_if, err: 1'b0, rdat: 128'(k + 100)});
      ack_pulse(t, 128'(k + 100));
      if (k == 9) begin
        if_req_i = 1'b0; d_req_i = 1'b0;
      end
      wait_check_done($sformatf("contend%0d", k), n);
    end
    if_req_i = 1'b0; d_req_i = 1'b0;

    // Reset in WAIT abandons the transaction; its late ack is ignored.
    @(negedge clk_i);
    d_req_i = 1'b1; d_we_i = 1'b0; d_adr_i = 32'h8000; d_sel_i = 16'h000F;
    wait_stb(ok);
    d_req_i = 1'b0;
    old_tid = bus_tid_o;
    @(negedge clk_i);
    chk("rst_pre_wait", {bus_cyc_o, bus_stb_o}, 2'b10);
    rst_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b1;
    chk("rst_mid_cyc", bus_cyc_o, 0);
    chk("rst_mid_tid", bus_tid_o, 4'd1);
    dones = 0;
    bus_ack_i = 1'b1; bus_tid_i = old_tid; bus_dat_i = 128'h1;
    @(negedge clk_i);
    bus_ack_i = 1'b0;
    repeat (5) begin
      if (if_done_o || d_done_o) dones++;
      @(negedge clk_i);
    end
    chk("rst_mid_no_done", dones, 0);
    exp_tid = 4'd1;
    run_vec(vecs[0], 10);
    chk("scoreboard_empty", sb_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/rf80386_bus_arbiter.md
RF80386_BUS_ARBITER -- requirements
Module: rf80386_bus_arbiter

Interface
REQ-001 SHALL have parameters: RTY_WAIT, default 8, backoff cycles after a retry response; TIMEOUT, default 31, cycles to wait for a response before abort; STARVE, default 4, consecutive data grants before a waiting ifetch is forced.
REQ-002 SHALL have ports (name direction width meaning):
clk_i  in  1  clock; the only clock
rst_i  in  1  synchronous, active-low reset
if_req_i  in  1  instruction-fetch request (read only)
if_adr_i  in  32  ifetch address, 16-byte aligned
if_done_o  out  1  ifetch complete pulse
if_err_o  out  1  ifetch aborted by timeout (valid with done)
d_req_i  in  1  data-port request
d_we_i  in  1  data write enable
d_adr_i  in  32  data address
d_sel_i  in  16  data byte lane selects
d_dat_i  in  128  data write data
d_done_o  out  1  data complete pulse
d_err_o  out  1  data aborted by timeout (valid with done)
rdat_o  out  128  read data, valid with either done
bus_cyc_o  out  1  bus cycle active
bus_stb_o  out  1  bus strobe
bus_we_o  out  1  bus write
bus_adr_o  out  32  bus address
bus_sel_o  out  16  bus byte selects
bus_dat_o  out  128  bus write data
bus_tid_o  out  4  transaction id
bus_ack_i  in  1  response ack
bus_rty_i  in  1  response retry
bus_tid_i  in  4  response transaction id
bus_dat_i  in  128  response data

Function
REQ-003 SHALL implement states IDLE, ISSUE, WAIT, BACKOFF.
REQ-004 IDLE: when any request is high, latch the winner's we/adr/sel/dat and owner, then go to ISSUE the next cycle.
REQ-005 Arbitration: data wins over ifetch, except that when ifetch is pending and starve_cnt==STARVE, ifetch wins.
REQ-006 starve_cnt SHALL increment on each data grant while if_req_i is high, saturate at STARVE, and clear on any ifetch grant.
REQ-007 An ifetch grant SHALL drive we=0 and sel=16'hFFFF.
REQ-008 ISSUE lasts one cycle: drive cyc=stb=1 with the latched fields, assign a new tid, then go to WAIT.
REQ-009 The tid counter SHALL be 4 bits, with a reset value of 1. It advances by 1 on each ISSUE and wraps 15->1; 0 is never issued.
REQ-010 WAIT: hold cyc=1 and stb=0, and count wait cycles starting from 0.
REQ-011 A response in WAIT counts only when bus_tid_i equals the outstanding tid. Responses with any other tid SHALL be ignored.
REQ-012 Matching ack SHALL:
- pulse the owner's done for one cycle;
- set rdat_o = bus_dat_i (writes as well);
- set err=0;
- return to IDLE.
REQ-013 Matching rty SHALL go to BACKOFF for RTY_WAIT cycles, then to ISSUE with the same latched fields and a new tid. Done is not asserted.
REQ-014 If ack and rty match in the same cycle, ack SHALL take precedence.
REQ-015 If the WAIT count reaches TIMEOUT with no matching response, the block SHALL pulse the owner's done with err=1 and rdat_o=0, then go to IDLE.
REQ-016 cyc SHALL be 0 in IDLE and in BACKOFF.
REQ-017 Requesters SHALL hold req and their fields stable until their done pulse. The block samples the fields only at grant.
REQ-018 A requester dropping req after grant SHALL NOT cancel the transaction.
REQ-019 The block SHALL grant at most one transaction at a time.
REQ-020 IDLE SHALL NOT grant in the cycle a done pulses. The earliest next grant is the cycle after done.
REQ-021 Dones SHALL be one cycle wide, mutually exclusive, and registered.

Reset
REQ-022 While rst_i is low at a clock edge, the block SHALL enter IDLE.
REQ-023 Reset SHALL drive all outputs to 0, except bus_tid_o = 1.
REQ-024 Reset SHALL clear starve_cnt, the wait count and the backoff count.
REQ-025 Reset mid-transaction SHALL abandon the transaction with no done pulse; later responses carrying its tid SHALL be ignored.

Verification
REQ-026 Data read: d_req, adr 0x1000, sel 0x000F -> ISSUE with tid 1; ack with tid 1 and data D three cycles later -> d_done=1 and rdat_o=D for one cycle, err=0.
REQ-027 Contention: if_req and d_req held continuously -> 4 data grants, then 1 ifetch grant, then the pattern repeats.
REQ-028 Retry: rty with matching tid 5 -> cyc low for 8 cycles, then reissue with tid 6 and identical adr/sel/dat; ack with tid 6 -> done.
REQ-029 Stale tid: in WAIT with tid 3, ack with tid 2 -> ignored; ack with tid 3 -> done.
REQ-030 Timeout: no response -> after 31 WAIT cycles, done=1 with err=1 and rdat_o=0; block back in IDLE.
REQ-031 Wrap and reset: 15 transactions -> tids run 1..15 then 1; reset asserted in WAIT -> IDLE, bus_cyc_o=0, no done, bus_tid_o=1.
